// File: rtl/ysyx_22041211_lsu_pkg.sv
// ysyx_22041211_lsu_pkg: shared FSM states, RV32 funct3 size codes and lane count for the LSU.
package ysyx_22041211_lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam int BYTE_LANES = 4;
endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// ysyx_22041211_lsu_align: store lane replication/strobes and load shift/extend (pure combinational).
module ysyx_22041211_lsu_align
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_off,
    input  logic [DATA_LEN-1:0]   i_wdata,
    input  logic [DATA_LEN-1:0]   i_rdata,
    output logic [DATA_LEN-1:0]   o_wdata,
    output logic [BYTE_LANES-1:0] o_wstrb,
    output logic [DATA_LEN-1:0]   o_rdata
);
    logic [DATA_LEN-1:0] w_sh;
    logic                w_b;
    logic                w_h;

    assign w_b  = i_funct3 == LB;
    assign w_h  = i_funct3 == LH;
    assign w_sh = i_rdata >> {i_off, 3'b000};

    // Strobe shifts stay 4 bits wide, so misaligned halfwords lose their upper lane.
    assign o_wdata = w_b ? {BYTE_LANES{i_wdata[7:0]}} :
                     w_h ? {(BYTE_LANES/2){i_wdata[15:0]}} : i_wdata;
    assign o_wstrb = w_b ? 4'b0001 << i_off :
                     w_h ? 4'b0011 << i_off : 4'b1111;

    always_comb begin
        o_rdata = w_sh;
        if (i_funct3 == LB)  o_rdata = {{(DATA_LEN-8){w_sh[7]}}, w_sh[7:0]};
        if (i_funct3 == LH)  o_rdata = {{(DATA_LEN-16){w_sh[15]}}, w_sh[15:0]};
        if (i_funct3 == LBU) o_rdata = {{(DATA_LEN-8){1'b0}}, w_sh[7:0]};
        if (i_funct3 == LHU) o_rdata = {{(DATA_LEN-16){1'b0}}, w_sh[15:0]};
    end
endmodule

// File: rtl/ysyx_22041211_lsu.sv
// ysyx_22041211_lsu: single-outstanding load/store unit, IDLE->REQ->WAIT->DONE handshake FSM.
// Define YSYX_22041211_MISALIGN_CHECK_EN to fault misaligned H/W accesses instead of issuing them.
module ysyx_22041211_lsu
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_LEN-1:0]   in_addr,
    input  logic [DATA_LEN-1:0]   in_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic [DATA_LEN-1:0]   mem_wdata,
    output logic [BYTE_LANES-1:0] mem_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_LEN-1:0]   mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_rdata,
    output logic                  out_err
);
    lsu_state_e            r_state;
    lsu_state_e            w_next;
    logic                  r_is_store;
    logic [2:0]            r_funct3;
    logic [ADDR_LEN-1:0]   r_addr;
    logic [DATA_LEN-1:0]   r_wdata;
    logic [DATA_LEN-1:0]   r_rdata;
    logic                  r_err;
    logic                  w_acc;
    logic                  w_mis;
    logic                  w_req;
    logic [DATA_LEN-1:0]   w_st_data;
    logic [DATA_LEN-1:0]   w_ld_data;
    logic [BYTE_LANES-1:0] w_strb;

`ifdef YSYX_22041211_MISALIGN_CHECK_EN
    assign w_mis = ((in_funct3 == LH || in_funct3 == LHU) && in_addr[0]) ||
                   (in_funct3 == LW && in_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_acc = in_valid && r_state == IDLE;
    assign w_req = r_state == REQ;

    ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_rdata),
        .o_wdata  (w_st_data),
        .o_wstrb  (w_strb),
        .o_rdata  (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (w_mis ? DONE : REQ) : IDLE;
            REQ:     w_next = mem_req_ready ? WAIT : REQ;
            WAIT:    w_next = mem_resp_valid ? DONE : WAIT;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_acc) begin
                r_is_store <= in_is_store;
                r_funct3   <= in_funct3;
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_rdata    <= '0;
                r_err      <= w_mis;
            end
            if (r_state == WAIT && mem_resp_valid) r_rdata <= r_is_store ? '0 : w_ld_data;
        end
    end

    // in_ready is masked by rst because the async reset already forces IDLE.
    assign in_ready      = r_state == IDLE && !rst;
    assign mem_req_valid = w_req;
    assign mem_wen       = w_req && r_is_store;
    assign mem_addr      = {r_addr[ADDR_LEN-1:2], 2'b00};
    assign mem_wdata     = w_st_data;
    assign mem_wstrb     = w_req && r_is_store ? w_strb : '0;
    assign out_valid     = r_state == DONE;
    assign out_rdata     = r_rdata;
    assign out_err       = r_err;
endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// tb_ysyx_22041211_lsu: vector table plus stall/reset sequences, results checked through an expected queue.
module tb_ysyx_22041211_lsu;
    import ysyx_22041211_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] mwdata;
        logic [3:0]  strb;
        logic [31:0] out;
        logic        err;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[11];

    ysyx_22041211_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_req(input vec_t v, input string tag);
        chk({tag, " req_valid"}, {31'b0, mem_req_valid}, 32'd1);
        chk({tag, " addr"}, mem_addr, {v.addr[31:2], 2'b00});
        chk({tag, " wen"}, {31'b0, mem_wen}, {31'b0, v.st});
        chk({tag, " wstrb"}, {28'b0, mem_wstrb}, {28'b0, v.strb});
        if (v.st) chk({tag, " wdata"}, mem_wdata, v.mwdata);
        chk({tag, " busy"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic do_op(input vec_t v, input int rdly, input int wdly, input int odly, input string tag);
        int n;
        vec_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_is_store = v.st;
        in_funct3 = v.f3;
        in_addr = v.addr;
        in_wdata = v.wdata;
        exp_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        in_addr = $urandom;
        in_wdata = $urandom;
        if (v.err) begin
            chk({tag, " no_req"}, {31'b0, mem_req_valid}, 32'd0);
        end else begin
            check_req(v, tag);
            repeat (rdly) begin
                @(negedge clk);
                check_req(v, {tag, " stall"});
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk({tag, " req_drop"}, {31'b0, mem_req_valid}, 32'd0);
            repeat (wdly) begin
                chk({tag, " early_out"}, {31'b0, out_valid}, 32'd0);
                @(negedge clk);
            end
            mem_resp_valid = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_rdata = $urandom;
        end
        chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " rdata"}, out_rdata, e.out);
            chk({tag, " err"}, {31'b0, out_err}, {31'b0, e.err});
            repeat (odly) begin
                @(negedge clk);
                chk({tag, " hold_valid"}, {31'b0, out_valid}, 32'd1);
                chk({tag, " hold_rdata"}, out_rdata, e.out);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        tbl[0] = '{1'b0, LW,  32'h80000004, 32'h0,        32'hDEADBEEF, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b0, LB,  32'h80000003, 32'h0,        32'h80FF0011, 32'h0,        4'b0000, 32'hFFFFFF80, 1'b0};
        tbl[2] = '{1'b0, LBU, 32'h80000003, 32'h0,        32'h80FF0011, 32'h0,        4'b0000, 32'h00000080, 1'b0};
        tbl[3] = '{1'b1, LH,  32'h80000002, 32'h1234ABCD, 32'h55555555, 32'hABCDABCD, 4'b1100, 32'h0,        1'b0};
        tbl[4] = '{1'b0, LH,  32'h80000002, 32'h0,        32'h80017FFF, 32'h0,        4'b0000, 32'hFFFF8001, 1'b0};
        tbl[5] = '{1'b0, LHU, 32'h80000000, 32'h0,        32'h1234F00D, 32'h0,        4'b0000, 32'h0000F00D, 1'b0};
        tbl[6] = '{1'b1, LB,  32'h80000001, 32'h000000A5, 32'h0,        32'hA5A5A5A5, 4'b0010, 32'h0,        1'b0};
        tbl[7] = '{1'b1, LW,  32'h80000008, 32'hCAFEBABE, 32'h0,        32'hCAFEBABE, 4'b1111, 32'h0,        1'b0};
        tbl[8] = '{1'b0, 3'b011, 32'h80000001, 32'h0,     32'h11223344, 32'h0,        4'b0000, 32'h00112233, 1'b0};
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
        tbl[9]  = '{1'b0, LW, 32'h80000002, 32'h0,        32'hAABBCCDD, 32'h0,        4'b0000, 32'h0,        1'b1};
        tbl[10] = '{1'b1, LH, 32'h80000003, 32'h0000BEEF, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1};
`else
        tbl[9]  = '{1'b0, LW, 32'h80000002, 32'h0,        32'hAABBCCDD, 32'h0,        4'b0000, 32'h0000AABB, 1'b0};
        tbl[10] = '{1'b1, LH, 32'h80000003, 32'h0000BEEF, 32'h0,        32'hBEEFBEEF, 4'b1000, 32'h0,        1'b0};
`endif
        rst = 1'b1;
        in_valid = 1'b0;
        in_is_store = 1'b0;
        in_funct3 = 3'b000;
        in_addr = '0;
        in_wdata = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst out_rdata", out_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) do_op(tbl[i], 0, 0, 0, $sformatf("vec%0d", i));

        do_op(tbl[0], 5, 3, 4, "stall_lw");
        do_op(tbl[3], 2, 1, 2, "stall_sh");

        in_valid = 1'b1;
        in_is_store = 1'b0;
        in_funct3 = LW;
        in_addr = 32'h80000010;
        exp_q.push_back(tbl[0]);
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst addr", mem_addr, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_req_ready = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b0;
        chk("late_resp out_valid", {31'b0, out_valid}, 32'd0);
        chk("late_resp req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("late_resp in_ready", {31'b0, in_ready}, 32'd1);
        chk("late_resp rdata", out_rdata, 32'd0);
        do_op(tbl[1], 0, 2, 1, "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22041211_lsu.md
# ysyx_22041211_lsu

Load/store unit sitting directly upstream of the data memory: it accepts one memory operation at a time from the execute stage (ALU-computed address, store data, funct3), formats it into a word-aligned, byte-strobed request to the data memory, waits for the response, and returns the aligned, sign- or zero-extended load result to writeback. A 4-state FSM with valid/ready handshakes on all three sides decouples core timing from memory latency.

## Interface
- DATA_LEN, 32, data width (fixed 32; byte lanes assume 4)
- ADDR_LEN, 32, address width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  LSU can accept (high only in IDLE)
- in_is_store  in  1  1 = store, 0 = load
- in_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_addr  in  ADDR_LEN  byte address (ALU result)
- in_wdata  in  DATA_LEN  store data (rs2, right-aligned)
- mem_req_valid  out  1  request to data memory
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  1 = write
- mem_addr  out  ADDR_LEN  {addr[ADDR_LEN-1:2], 2'b00}
- mem_wdata  out  DATA_LEN  lane-replicated store data
- mem_wstrb  out  4  byte strobes (0000 on loads)
- mem_resp_valid  in  1  read data / write ack
- mem_rdata  in  DATA_LEN  full read word
- out_valid  out  1  result ready for writeback
- out_ready  in  1  writeback accepts
- out_rdata  out  DATA_LEN  extended load value (0 for stores)
- out_err  out  1  misaligned access flag

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready latch is_store, funct3, addr, wdata -> REQ. Misaligned with check enabled -> DONE directly, out_err=1.
- REQ: mem_req_valid=1, address/data/strobe/wen stable from latched regs. On mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid latch formatted result -> DONE.
- DONE: out_valid=1, outputs held until out_ready -> IDLE.
- Store formatting: B: wdata={4{b}}, wstrb=0001<<off; H: {2{h}}, wstrb=(0011<<off)[3:0]; W and undefined funct3 (011,110,111): wdata as-is, 1111. off=addr[1:0].
- Load formatting: word = mem_rdata >> (8*off); B/H sign-extend bit 7/15; BU/HU zero-extend; W and undefined funct3: whole shifted word.
- mem_resp_valid outside WAIT ignored; mem_req_ready outside REQ ignored.

## Timing
- Reset values: in_ready=0 during reset, 1 on first cycle after (IDLE); mem_req_valid, mem_wen, out_valid, out_err=0; mem_addr, mem_wdata, out_rdata=0; mem_wstrb=0000.
- Minimum latency: accept cycle N, request N+1, response earliest N+2, out_valid N+3. Exactly one outstanding op.
- Request signals must not change while mem_req_valid=1 && !mem_req_ready.
- out_rdata/out_err stable while out_valid && !out_ready; next op accepted no earlier than the cycle after DONE handshake.
- Reset mid-operation (any state): immediate return to IDLE, all outputs to reset values; a late memory response after reset is dropped.

## Configuration
- YSYX_22041211_MISALIGN_CHECK_EN defined: H with addr[0]=1, W with addr[1:0]!=0 -> no memory request, DONE with out_err=1, out_rdata=0.
- Undefined: out_err tied 0; misaligned ops issued normally, strobe truncated to 4 bits, load takes shifted word (upper lanes zero-filled).

## Structure
- Package ysyx_22041211_lsu_pkg: state enum (IDLE/REQ/WAIT/DONE), funct3 constants (LB, LH, LW, LBU, LHU), byte-lane count localparam.
- Sub-module ysyx_22041211_lsu_align: combinational strobe/store-replication and load shift/extend; top holds FSM and registers.

## Test plan
- LW addr 0x80000004, mem_rdata 0xDEADBEEF, ready/resp immediate -> mem_addr 0x80000004, wstrb 0000, out_rdata 0xDEADBEEF at cycle N+3.
- LB addr 0x80000003, mem_rdata 0x80FF0011 -> out_rdata 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x80000002, wdata 0x1234ABCD -> mem_wdata 0xABCDABCD, wstrb 1100, mem_wen 1, out_rdata 0.
- mem_req_ready held low 5 cycles then high, resp 3 cycles later -> request signals stable throughout, in_ready 0, one out_valid pulse held until out_ready.
- LW addr 0x80000002 with check enabled -> no mem_req_valid, out_valid with out_err 1 next cycle; disabled -> request issued, out_err 0.
- rst asserted in WAIT, resp arrives after release -> outputs reset immediately, response ignored, in_ready 1.
